// File: rtl/approx_mul_pkg.sv
// Shared widths and constants for the approximate-multiplier arbiter slice.
package approx_mul_pkg;
    localparam int OPW     = 8;   // operand width
    localparam int PRODW   = 16;  // product width
    localparam int TRUNC_L = 2;   // low multiplicand bits dropped by the approximation
    localparam int CNTW    = 16;  // completed-operation counter width
endpackage

// File: rtl/approx_mul_arbiter_if.sv
// Request/response bus between requesters, the arbiter and its downstream consumer.
interface approx_mul_arbiter_if
    import approx_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) ();
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [OPW*NREQ-1:0] req_x;
    logic [OPW*NREQ-1:0] req_y;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [PRODW-1:0]    rsp_z;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_z
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_z
    );
endinterface

// File: rtl/approx_mul8_core.sv
// Combinational 8x8 multiplier: exact product or truncated product with
// compensation terms for the dropped low multiplicand bits.
module approx_mul8_core
    import approx_mul_pkg::*;
(
    input  logic [OPW-1:0]   x,
    input  logic [OPW-1:0]   y,
    input  logic             exact,
    output logic [PRODW-1:0] z
);

    function automatic logic [PRODW-1:0] approx_product(input logic [OPW-1:0] xa,
                                                        input logic [OPW-1:0] ya);
        logic             a;
        logic             b;
        logic [PRODW-1:0] yw;
        logic [PRODW-1:0] xw;
        logic [PRODW-1:0] p;
        a  = xa[0] & ya[7];
        b  = xa[1] & ya[6];
        yw = PRODW'(ya);
        xw = PRODW'(xa >> TRUNC_L);
        p  = (yw * xw) << TRUNC_L;
        p  = p + (PRODW'(a ^ b) << 7) + (PRODW'(a & b) << 8)
               + (PRODW'(xa[1] & ya[7]) << 8);
        return p;
    endfunction

    function automatic logic [PRODW-1:0] exact_product(input logic [OPW-1:0] xa,
                                                       input logic [OPW-1:0] ya);
        return PRODW'(ya) * PRODW'(xa);
    endfunction

    assign z = exact ? exact_product(x, y) : approx_product(x, y);

endmodule

// File: rtl/approx_mul_arbiter.sv
// Round-robin arbiter feeding a shared two-stage multiplier pipeline with
// valid/ready backpressure on both sides.
module approx_mul_arbiter
    import approx_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_exact,
    approx_mul_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [CNTW-1:0]      op_count
);

    logic [IDW-1:0]   rr_ptr;
    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic             s2_load;
    logic             s1_can;
    logic             accept;

    logic             vld_p1;
    logic [OPW-1:0]   x_p1;
    logic [OPW-1:0]   y_p1;
    logic [IDW-1:0]   id_p1;
    logic             exact_p1;
    logic [PRODW-1:0] core_z;

    logic             vld_p2;
    logic [PRODW-1:0] z_p2;
    logic [IDW-1:0]   id_p2;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin : scan
            int cand;
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(cand);
            end
        end
    end

    assign s2_load = !vld_p2 || bus.rsp_ready;
    assign s1_can  = !vld_p1 || s2_load;
    // rst_n gating keeps req_ready low for the whole reset interval.
    assign accept  = rst_n && gnt_found && s1_can;

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            z_p2     <= '0;
            id_p2    <= '0;
            op_count <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
            end
            // S1 boundary: fills on accept, empties when its op moves to S2.
            if (accept)       vld_p1 <= 1'b1;
            else if (s2_load) vld_p1 <= 1'b0;
            // S2 boundary: product registered straight onto the response bus.
            if (s2_load) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    z_p2  <= core_z;
                    id_p2 <= id_p1;
                end
            end
            if (vld_p2 && bus.rsp_ready) op_count <= op_count + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            x_p1     <= bus.req_x[gnt_idx*OPW +: OPW];
            y_p1     <= bus.req_y[gnt_idx*OPW +: OPW];
            id_p1    <= gnt_idx;
            exact_p1 <= cfg_exact;
        end
    end

    approx_mul8_core u_core (
        .x     (x_p1),
        .y     (y_p1),
        .exact (exact_p1),
        .z     (core_z)
    );

    assign bus.rsp_valid = vld_p2;
    assign bus.rsp_z     = z_p2;
    assign bus.rsp_id    = id_p2;
    assign busy          = vld_p1 | vld_p2;

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Directed bench for approx_mul_arbiter: reset, products, arbitration,
// backpressure, mid-operation reset and op_count wrap.
module tb_approx_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_exact = 1'b0;
    logic        busy;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    int xs [4];
    int ys [4];

    approx_mul_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

    approx_mul_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_exact (cfg_exact),
        .bus       (bus),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int x, input int y);
        xs[i] = x;
        ys[i] = y;
        bus.req_x[i*8 +: 8] = 8'(x);
        bus.req_y[i*8 +: 8] = 8'(y);
    endtask

    // Reference product written in plain integer arithmetic.
    function automatic int model(input int x, input int y, input bit exact);
        int a, b, c, r;
        if (exact) return x * y;
        a = (x % 2) * ((y / 128) % 2);
        b = ((x / 2) % 2) * ((y / 64) % 2);
        c = ((x / 2) % 2) * ((y / 128) % 2);
        r = y * (x / 4) * 4 + ((a + b) % 2) * 128 + (a * b) * 256 + c * 256;
        return r % 65536;
    endfunction

    initial begin
        int accepts;
        int sent;
        int bound;
        int g;
        int e;
        int exp_q[$];

        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.rsp_ready = 1'b1;

        // Reset state, with requests pending
        rst_n = 1'b0;
        bus.req_valid = 4'hF;
        repeat (2) tick();
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_z", 32'(bus.rsp_z), 0);
        check("rst_rsp_id", 32'(bus.rsp_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_op_count", 32'(op_count), 0);
        bus.req_valid = '0;
        rst_n = 1'b1;

        // A: 255*255 approximate, requester 0, two-cycle latency
        set_op(0, 255, 255);
        cfg_exact = 1'b0;
        bus.req_valid = 4'b0001;
        #1;
        check("A_ready", 32'(bus.req_ready), 1);
        tick();
        bus.req_valid = '0;
        #1;
        check("A_lat1_valid", 32'(bus.rsp_valid), 0);
        check("A_lat1_busy", 32'(busy), 1);
        tick();
        check("A_valid", 32'(bus.rsp_valid), 1);
        check("A_z", 32'(bus.rsp_z), 64772);
        check("A_id", 32'(bus.rsp_id), 0);
        tick();
        check("A_done_valid", 32'(bus.rsp_valid), 0);
        check("A_op_count", 32'(op_count), 1);
        check("A_busy", 32'(busy), 0);

        // B: 3*192 approximate then exact; cfg change affects only the later op
        set_op(1, 3, 192);
        bus.req_valid = 4'b0010;
        #1;
        check("B_ready1", 32'(bus.req_ready), 2);
        tick();
        cfg_exact = 1'b1;
        set_op(2, 3, 192);
        bus.req_valid = 4'b0100;
        #1;
        check("B_ready2", 32'(bus.req_ready), 4);
        tick();
        bus.req_valid = '0;
        cfg_exact = 1'b0;
        check("B_z_approx", 32'(bus.rsp_z), 512);
        check("B_id1", 32'(bus.rsp_id), 1);
        tick();
        check("B_z_exact", 32'(bus.rsp_z), 576);
        check("B_id2", 32'(bus.rsp_id), 2);
        tick();
        check("B_done_valid", 32'(bus.rsp_valid), 0);
        check("B_op_count", 32'(op_count), 3);

        // D: backpressure for 5 cycles, pointer currently at 3
        for (int i = 0; i < 4; i++) set_op(i, 10 + 37 * i, 200 - 13 * i);
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b0;
        accepts = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if ((bus.req_valid & bus.req_ready) != 0) accepts++;
            if (c == 0) check("D_ready_c0", 32'(bus.req_ready), 8);
            if (c == 1) check("D_ready_c1", 32'(bus.req_ready), 1);
            if (c >= 2) begin
                check("D_ready_full", 32'(bus.req_ready), 0);
                check("D_hold_valid", 32'(bus.rsp_valid), 1);
                check("D_hold_id", 32'(bus.rsp_id), 3);
                check("D_hold_z", 32'(bus.rsp_z), 32'(model(xs[3], ys[3], 1'b0)));
            end
            tick();
        end
        check("D_accepts", 32'(accepts), 2);
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        tick();
        check("D_drain_valid", 32'(bus.rsp_valid), 1);
        check("D_drain_id", 32'(bus.rsp_id), 0);
        check("D_drain_z", 32'(bus.rsp_z), 32'(model(xs[0], ys[0], 1'b0)));
        tick();
        check("D_empty", 32'(bus.rsp_valid), 0);
        check("D_op_count", 32'(op_count), 5);

        // E: reset while both stages are full
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check("E_full_busy", 32'(busy), 1);
        check("E_full_valid", 32'(bus.rsp_valid), 1);
        check("E_full_id", 32'(bus.rsp_id), 1);
        rst_n = 1'b0;
        #1;
        check("E_rst_valid", 32'(bus.rsp_valid), 0);
        check("E_rst_busy", 32'(busy), 0);
        check("E_rst_op_count", 32'(op_count), 0);
        check("E_rst_ready", 32'(bus.req_ready), 0);
        check("E_rst_z", 32'(bus.rsp_z), 0);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("E_no_stale", 32'(bus.rsp_valid), 0);
        end

        // C: all requesters valid, round robin 0,1,2,3,0 with exact products
        for (int i = 0; i < 4; i++) set_op(i, 17 * i + 5, 250 - 29 * i);
        cfg_exact = 1'b1;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) bus.req_valid = '0;
            #1;
            if (k < 5) check("C_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                check("C_rsp_valid", 32'(bus.rsp_valid), 1);
                check("C_rsp_id", 32'(bus.rsp_id), 32'((k - 2) % 4));
                check("C_rsp_z", 32'(bus.rsp_z),
                      32'(model(xs[(k - 2) % 4], ys[(k - 2) % 4], 1'b1)));
            end
            tick();
        end
        check("C_op_count", 32'(op_count), 5);

        // F: 65537 completed operations, op_count wraps to 1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("F_start_count", 32'(op_count), 0);
        sent = 0;
        bound = 0;
        while ((sent < 65537 || exp_q.size() > 0) && bound < 70000) begin
            if (sent < 65537) begin
                for (int i = 0; i < 4; i++)
                    set_op(i, int'($urandom_range(255)), int'($urandom_range(255)));
                cfg_exact = 1'($urandom_range(1));
                bus.req_valid = 4'hF;
            end else begin
                bus.req_valid = '0;
            end
            #1;
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("F_unexpected_rsp", 32'(bus.rsp_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("F_id", 32'(bus.rsp_id), 32'(e >> 16));
                    check("F_z", 32'(bus.rsp_z), 32'(e & 32'hFFFF));
                end
            end
            if ((bus.req_valid & bus.req_ready) != 0) begin
                g = 0;
                for (int i = 0; i < 4; i++) if (bus.req_ready[i]) g = i;
                exp_q.push_back((g << 16) | model(xs[g], ys[g], cfg_exact));
                sent++;
            end
            tick();
            bound++;
        end
        check("F_sent", 32'(sent), 65537);
        check("F_drained", 32'(exp_q.size()), 0);
        check("F_op_count_wrap", 32'(op_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_mul_arbiter.md
APPROX_MUL_ARBITER -- requirements
Module: approx_mul_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing the multiplier (2..8).
REQ-002 Parameter IDW, default 2, SHALL set the requester-index width and SHALL equal clog2(NREQ).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NREQ  per-requester operation-request flag.
REQ-006 req_ready  output  NREQ  per-requester accept flag; a request transfers when req_valid[i] and req_ready[i] are both high.
REQ-007 req_x  input  8*NREQ  multiplicand x, requester i in bits [8i+7:8i].
REQ-008 req_y  input  8*NREQ  multiplier y, requester i in bits [8i+7:8i].
REQ-009 cfg_exact  input  1  selects exact (1) or approximate (0) product; sampled per operation at acceptance.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  downstream accepts result.
REQ-012 rsp_id  output  IDW  index of the requester that issued the result.
REQ-013 rsp_z  output  16  unsigned product.
REQ-014 busy  output  1  high when any pipeline stage holds an operation.
REQ-015 op_count  output  16  number of completed response handshakes.

Function
REQ-016 The approximate product SHALL be ((y*x[7:2])<<2) + (a^b)<<7 + (a&b)<<8 + (x[1]&y[7])<<8, where a=x[0]&y[7] and b=x[1]&y[6], computed at 16 bits with carry out of bit 15 discarded.
REQ-017 The exact product SHALL be the full 16-bit y*x.
REQ-018 Arbitration SHALL be round-robin: the search starts at pointer rr_ptr, and the first i (modulo NREQ) with req_valid[i] high is granted.
REQ-019 After each accepted request from requester g, rr_ptr SHALL become (g+1) mod NREQ; rr_ptr SHALL be unchanged when nothing is accepted.
REQ-020 At most one req_ready bit SHALL be high per cycle, only for the granted requester and only when stage S1 can accept.
REQ-021 req_ready MAY depend combinationally on req_valid; it SHALL NOT depend on req_x or req_y.
REQ-022 Pipeline stage S1 SHALL register x, y, the requester index and the cfg_exact sample on acceptance.
REQ-023 Stage S2 SHALL register the product, the requester index and a valid flag; rsp_valid, rsp_z and rsp_id SHALL be driven directly from S2 registers.
REQ-024 S2 SHALL load when S2 is empty or rsp_ready is high.
REQ-025 S1 SHALL accept when S1 is empty or S1 transfers into S2 in the same cycle.
REQ-026 Accept-to-rsp_valid latency SHALL be exactly 2 cycles with no backpressure, and one result per cycle SHALL be sustained while rsp_ready stays high.
REQ-027 While rsp_valid is high and rsp_ready is low, rsp_z and rsp_id SHALL hold stable.
REQ-028 When both stages are full and rsp_ready is low, req_ready SHALL be all-zero.
REQ-029 No accepted operation SHALL be dropped, duplicated or reordered.
REQ-030 op_count SHALL increment on each rsp_valid&rsp_ready and wrap from 0xFFFF to 0.
REQ-031 A change of cfg_exact SHALL affect only operations accepted after the change.

Reset
REQ-032 While rst_n is low: req_ready=0, rsp_valid=0, rsp_z=0, rsp_id=0, busy=0, op_count=0, rr_ptr=0, both stage valid flags 0.
REQ-033 An assertion of rst_n mid-operation SHALL discard all in-flight operations immediately.
REQ-034 After reset deasserts, requests SHALL be accepted from the first rising edge.

Structure
REQ-035 Shared package approx_mul_pkg SHALL hold the operand width (8), product width (16), truncation level L=2 and the op_count width.
REQ-036 The combinational multiplier SHALL be a sub-module approx_mul8_core (inputs x, y, exact; output z), placed between S1 and S2.

Verification
REQ-037 x=255, y=255, cfg_exact=0, requester 0 -> rsp_z=64772, rsp_id=0, two cycles after accept.
REQ-038 x=3, y=192, cfg_exact=0 -> rsp_z=512; the same operands with cfg_exact=1 -> rsp_z=576.
REQ-039 All four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0, one accept per cycle, rsp_id following the same order.
REQ-040 rsp_ready held low for 5 cycles with continuous requests -> exactly 2 accepts, then req_ready=0 and rsp_z stable; on release, results drain in order.
REQ-041 rst_n pulsed low while both stages are full -> rsp_valid=0 and busy=0 immediately, op_count=0, and no stale response afterwards.
REQ-042 65537 back-to-back completed operations -> op_count=1, and every rsp_z matches a reference model of REQ-016 and REQ-017.
